// File: rtl/dmem_port_if.sv
// Request/response port between one data-memory client (CPU or DMA) and the arbiter.
interface dmem_port_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) ();
    logic                     valid;
    logic                     ready;
    logic                     WE;
    logic [1:0]               dataType;
    logic [ADDRESS_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0]    WD;
    logic                     rvalid;
    logic [DATA_WIDTH-1:0]    RD;
    logic                     err;

    modport master (
        output valid, WE, dataType, A, WD,
        input  ready, rvalid, RD, err
    );

    modport slave (
        input  valid, WE, dataType, A, WD,
        output ready, rvalid, RD, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data RAM.
// Each transaction takes IDLE -> ACCESS -> RESP, one transaction per three cycles.
module dmem_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    dmem_port_if.slave               p0,
    dmem_port_if.slave               p1,
    output logic                     ram_WE,
    output logic [1:0]               ram_dataType,
    output logic [ADDRESS_WIDTH-1:0] ram_A,
    output logic [DATA_WIDTH-1:0]    ram_WD,
    input  logic [DATA_WIDTH-1:0]    ram_RD
);

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    typedef struct packed {
        logic                     owner;
        logic                     we;
        logic [1:0]               dtype;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
    } req_t;

    state_t                  state_q;
    logic                    ptr_q;
    req_t                    req_q;
    req_t                    req_d;
    logic [DATA_WIDTH-1:0]   resp_rd_q;
    logic                    resp_err_q;

    logic                    gnt0_c;
    logic                    gnt1_c;
    logic                    idle_c;
    logic                    accept_c;
    logic                    err_c;
    logic                    in_access_c;
    logic                    in_resp_c;
    logic                    rv0_c;
    logic                    rv1_c;

    // Grant: a lone requester wins, otherwise the priority pointer decides.
    always_comb begin
        gnt1_c   = p1.valid && (!p0.valid || ptr_q);
        gnt0_c   = p0.valid && !gnt1_c;
        idle_c   = (state_q == IDLE) && !rst;
        accept_c = idle_c && (p0.valid || p1.valid);
        p0.ready = idle_c && gnt0_c;
        p1.ready = idle_c && gnt1_c;
    end

    // Payload of the granted port, captured on accept.
    always_comb begin
        req_d.owner = gnt1_c;
        if (gnt1_c) begin
            req_d.we    = p1.WE;
            req_d.dtype = p1.dataType;
            req_d.addr  = p1.A;
            req_d.wdata = p1.WD;
        end else begin
            req_d.we    = p0.WE;
            req_d.dtype = p0.dataType;
            req_d.addr  = p0.A;
            req_d.wdata = p0.WD;
        end
    end

    // Alignment / reserved-size check on the latched request.
    always_comb begin
        err_c = 1'b1;
        case (req_q.dtype)
            DT_WORD: err_c = (req_q.addr[1:0] != 2'b00);
            DT_HALF: err_c = req_q.addr[0];
            DT_BYTE: err_c = 1'b0;
            default: err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            req_q      <= '0;
            resp_rd_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        req_q   <= req_d;
                        ptr_q   <= ~ptr_q;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_rd_q  <= (req_q.we || err_c) ? '0 : ram_RD;
                    resp_err_q <= err_c;
                    state_q    <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM side is driven only during ACCESS and is silenced by reset immediately.
    always_comb begin
        in_access_c  = (state_q == ACCESS) && !rst;
        ram_WE       = in_access_c && req_q.we && !err_c;
        ram_dataType = in_access_c ? req_q.dtype : 2'b00;
        ram_A        = in_access_c ? req_q.addr  : '0;
        ram_WD       = in_access_c ? req_q.wdata : '0;
    end

    // Response goes only to the owner; the other port sees all zeros.
    always_comb begin
        in_resp_c = (state_q == RESP) && !rst;
        rv0_c     = in_resp_c && !req_q.owner;
        rv1_c     = in_resp_c && req_q.owner;
        p0.rvalid = rv0_c;
        p1.rvalid = rv1_c;
        p0.RD     = rv0_c ? resp_rd_q : '0;
        p1.RD     = rv1_c ? resp_rd_q : '0;
        p0.err    = rv0_c && resp_err_q;
        p1.err    = rv1_c && resp_err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        ram_WE;
    logic [1:0]  ram_dataType;
    logic [31:0] ram_A;
    logic [31:0] ram_WD;
    logic [31:0] ram_RD;
    logic        ovr_en;
    logic [31:0] ovr_val;
    int          n_cmp;
    int          n_bad;

    dmem_port_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) p0_if ();
    dmem_port_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) p1_if ();

    dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0           (p0_if),
        .p1           (p1_if),
        .ram_WE       (ram_WE),
        .ram_dataType (ram_dataType),
        .ram_A        (ram_A),
        .ram_WD       (ram_WD),
        .ram_RD       (ram_RD)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign ram_RD = ovr_en ? ovr_val : memf(ram_A);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic we, input logic [1:0] dt,
                          input logic [31:0] a, input logic [31:0] wd);
        p0_if.valid = v; p0_if.WE = we; p0_if.dataType = dt; p0_if.A = a; p0_if.WD = wd;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [1:0] dt,
                          input logic [31:0] a, input logic [31:0] wd);
        p1_if.valid = v; p1_if.WE = we; p1_if.dataType = dt; p1_if.A = a; p1_if.WD = wd;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive0(1'b1, 1'b1, 2'b00, 32'h4, 32'h11);
        drive1(1'b1, 1'b1, 2'b00, 32'h8, 32'h22);
        step();
        step();
        sample();
        n_cmp++; if (p0_if.ready !== 1'b0) begin n_bad++; $display("FAIL rst_p0_ready: got %b want 0", p0_if.ready); end
        n_cmp++; if (p1_if.ready !== 1'b0) begin n_bad++; $display("FAIL rst_p1_ready: got %b want 0", p1_if.ready); end
        n_cmp++; if ({p1_if.rvalid, p0_if.rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid: got %b want 00", {p1_if.rvalid, p0_if.rvalid}); end
        n_cmp++; if ({ram_WE, ram_dataType, ram_A, ram_WD} !== 67'd0) begin n_bad++; $display("FAIL rst_ram: got we=%b dt=%b a=%h wd=%h want 0", ram_WE, ram_dataType, ram_A, ram_WD); end
        n_cmp++; if ({p0_if.RD, p1_if.RD, p0_if.err, p1_if.err} !== 66'd0) begin n_bad++; $display("FAIL rst_resp: got %h %h %b %b want 0", p0_if.RD, p1_if.RD, p0_if.err, p1_if.err); end
        step();
        rst = 1'b0;
        sample();
        n_cmp++; if ({p1_if.ready, p0_if.ready} !== 2'b01) begin n_bad++; $display("FAIL rst_first_accept: got %b want 01", {p1_if.ready, p0_if.ready}); end
        step();
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        step();
        step();
    endtask

    task automatic test_single_load();
        apply_reset();
        ovr_en = 1'b1; ovr_val = 32'hDEADBEEF;
        drive0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        sample();
        n_cmp++; if ({p1_if.ready, p0_if.ready} !== 2'b01) begin n_bad++; $display("FAIL load_ready: got %b want 01", {p1_if.ready, p0_if.ready}); end
        step();
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        n_cmp++; if (ram_A !== 32'h10) begin n_bad++; $display("FAIL load_ram_A: got %h want 00000010", ram_A); end
        n_cmp++; if (ram_WE !== 1'b0) begin n_bad++; $display("FAIL load_ram_WE: got %b want 0", ram_WE); end
        n_cmp++; if (ram_dataType !== 2'b00) begin n_bad++; $display("FAIL load_ram_dt: got %b want 00", ram_dataType); end
        step();
        sample();
        n_cmp++; if (p0_if.rvalid !== 1'b1) begin n_bad++; $display("FAIL load_rvalid: got %b want 1", p0_if.rvalid); end
        n_cmp++; if (p0_if.RD !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_RD: got %h want deadbeef", p0_if.RD); end
        n_cmp++; if (p0_if.err !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", p0_if.err); end
        n_cmp++; if ({p1_if.rvalid, p1_if.RD} !== 33'd0) begin n_bad++; $display("FAIL load_other_port: got %b %h want 0", p1_if.rvalid, p1_if.RD); end
        step();
        sample();
        n_cmp++; if (p0_if.rvalid !== 1'b0) begin n_bad++; $display("FAIL load_rvalid_once: got %b want 0", p0_if.rvalid); end
        ovr_en = 1'b0;
    endtask

    task automatic test_store();
        apply_reset();
        drive1(1'b1, 1'b1, 2'b10, 32'h23, 32'h000000AB);
        sample();
        n_cmp++; if ({p1_if.ready, p0_if.ready} !== 2'b10) begin n_bad++; $display("FAIL store_ready: got %b want 10", {p1_if.ready, p0_if.ready}); end
        step();
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        n_cmp++; if ({ram_WE, ram_dataType} !== 3'b110) begin n_bad++; $display("FAIL store_we_dt: got %b%b want 110", ram_WE, ram_dataType); end
        n_cmp++; if ({ram_A, ram_WD} !== {32'h23, 32'hAB}) begin n_bad++; $display("FAIL store_addr_data: got %h %h want 23 ab", ram_A, ram_WD); end
        step();
        sample();
        n_cmp++; if (ram_WE !== 1'b0) begin n_bad++; $display("FAIL store_we_one_cycle: got %b want 0", ram_WE); end
        n_cmp++; if ({p1_if.rvalid, p1_if.RD, p1_if.err} !== {1'b1, 32'h0, 1'b0}) begin n_bad++; $display("FAIL store_resp: got rv=%b rd=%h err=%b want 1 0 0", p1_if.rvalid, p1_if.RD, p1_if.err); end
        n_cmp++; if (p0_if.rvalid !== 1'b0) begin n_bad++; $display("FAIL store_other_rvalid: got %b want 0", p0_if.rvalid); end
        step();
    endtask

    task automatic test_contention();
        logic e0;
        logic e1;
        rst = 1'b1;
        drive0(1'b1, 1'b0, 2'b00, 32'h100, 32'h0);
        drive1(1'b1, 1'b0, 2'b00, 32'h200, 32'h0);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            e0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
            e1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
            sample();
            n_cmp++; if ({p1_if.ready, p0_if.ready} !== {e1, e0}) begin n_bad++; $display("FAIL contention_ready c=%0d: got %b want %b", c, {p1_if.ready, p0_if.ready}, {e1, e0}); end
            if (c % 3 == 2) begin
                n_cmp++;
                if ({p1_if.rvalid, p0_if.rvalid} !== (((c / 3) % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_bad++; $display("FAIL contention_rvalid c=%0d: got %b", c, {p1_if.rvalid, p0_if.rvalid});
                end
            end
            step();
        end
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        step();
        step();
    endtask

    task automatic test_misaligned();
        apply_reset();
        ovr_en = 1'b1; ovr_val = 32'hFFFFFFFF;
        drive0(1'b1, 1'b1, 2'b00, 32'h6, 32'h12345678);
        for (int k = 0; k < 3; k++) begin
            sample();
            n_cmp++; if (ram_WE !== 1'b0) begin n_bad++; $display("FAIL misaligned_we k=%0d: got %b want 0", k, ram_WE); end
            if (k == 0) begin
                n_cmp++; if (p0_if.ready !== 1'b1) begin n_bad++; $display("FAIL misaligned_ready: got %b want 1", p0_if.ready); end
            end
            if (k == 2) begin
                n_cmp++; if ({p0_if.rvalid, p0_if.err, p0_if.RD} !== {1'b1, 1'b1, 32'h0}) begin n_bad++; $display("FAIL misaligned_resp: got rv=%b err=%b rd=%h want 1 1 0", p0_if.rvalid, p0_if.err, p0_if.RD); end
            end
            step();
            if (k == 0) drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive1(1'b1, 1'b1, 2'b00, 32'h30, 32'h55);
        sample();
        n_cmp++; if (p1_if.ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_accept: got %b want 1", p1_if.ready); end
        step();
        rst = 1'b1;
        drive1(1'b1, 1'b1, 2'b00, 32'h34, 32'h66);
        sample();
        n_cmp++; if (ram_WE !== 1'b0) begin n_bad++; $display("FAIL rstmid_we: got %b want 0", ram_WE); end
        n_cmp++; if ({p1_if.ready, p1_if.rvalid} !== 2'b00) begin n_bad++; $display("FAIL rstmid_ready_rvalid: got %b want 00", {p1_if.ready, p1_if.rvalid}); end
        step();
        rst = 1'b0;
        sample();
        n_cmp++; if (p1_if.rvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_rvalid: got %b want 0", p1_if.rvalid); end
        n_cmp++; if ({p1_if.ready, p0_if.ready} !== 2'b10) begin n_bad++; $display("FAIL rstmid_pending_p1: got %b want 10", {p1_if.ready, p0_if.ready}); end
        step();
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        n_cmp++; if ({ram_WE, ram_A} !== {1'b1, 32'h34}) begin n_bad++; $display("FAIL rstmid_retry_access: got we=%b a=%h want 1 34", ram_WE, ram_A); end
        step();
        sample();
        n_cmp++; if (p1_if.rvalid !== 1'b1) begin n_bad++; $display("FAIL rstmid_retry_resp: got %b want 1", p1_if.rvalid); end
        step();
    endtask

    task automatic test_payload_stability();
        apply_reset();
        drive0(1'b1, 1'b0, 2'b00, 32'h40, 32'h0);
        sample();
        n_cmp++; if (p0_if.ready !== 1'b1) begin n_bad++; $display("FAIL stable_accept: got %b want 1", p0_if.ready); end
        step();
        drive0(1'b1, 1'b1, 2'b00, 32'h80, 32'h99);
        sample();
        n_cmp++; if ({ram_A, ram_WE} !== {32'h40, 1'b0}) begin n_bad++; $display("FAIL stable_ram_A: got a=%h we=%b want 40 0", ram_A, ram_WE); end
        step();
        sample();
        n_cmp++; if (p0_if.RD !== memf(32'h40)) begin n_bad++; $display("FAIL stable_RD: got %h want %h", p0_if.RD, memf(32'h40)); end
        step();
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        logic        pend [2];
        logic        pwe  [2];
        logic [1:0]  pdt  [2];
        logic [31:0] pa   [2];
        logic [31:0] pwd  [2];
        logic        e_we [4];
        logic [31:0] e_a  [4];
        logic [1:0]  e_rv [4];
        logic [31:0] e_rd [4];
        logic        e_err[4];
        logic [1:0]  e_rdy;
        logic        ptr;
        logic        errm;
        int          next_free;
        int          acc_port;
        int          gi;
        int          s;
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        apply_reset();
        ptr = 1'b0; next_free = 0; acc_port = -1;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pwe[i] = 1'b0; pdt[i] = 2'b00; pa[i] = 32'h0; pwd[i] = 32'h0;
        end
        for (int i = 0; i < 4; i++) begin
            e_we[i] = 1'b0; e_a[i] = 32'h0; e_rv[i] = 2'b00; e_rd[i] = 32'h0; e_err[i] = 1'b0;
        end
        for (int c = 0; c < 700; c++) begin
            if (acc_port >= 0) pend[acc_port] = 1'b0;
            acc_port = -1;
            if (c < 660) begin
                for (int p = 0; p < 2; p++) begin
                    if (!pend[p] && ($urandom_range(0, 2) == 0)) begin
                        pend[p] = 1'b1;
                        pwe[p]  = 1'($urandom_range(0, 1));
                        pdt[p]  = 2'($urandom_range(0, 3));
                        pa[p]   = $urandom & 32'h0000_0FFF;
                        pwd[p]  = $urandom;
                    end
                end
            end
            drive0(pend[0], pwe[0], pdt[0], pa[0], pwd[0]);
            drive1(pend[1], pwe[1], pdt[1], pa[1], pwd[1]);
            e_rdy = 2'b00;
            if (c >= next_free && (pend[0] || pend[1])) begin
                gi = (pend[0] && pend[1]) ? int'(ptr) : (pend[1] ? 1 : 0);
                e_rdy[gi] = 1'b1;
                ptr = ~ptr;
                next_free = c + 3;
                acc_port = gi;
                errm = (pdt[gi] == 2'b11) || (pdt[gi] == 2'b01 && pa[gi][0]) ||
                       (pdt[gi] == 2'b00 && pa[gi][1:0] != 2'b00);
                e_we[(c + 1) % 4]  = pwe[gi] && !errm;
                e_a[(c + 1) % 4]   = pa[gi];
                e_rv[(c + 2) % 4]  = (gi == 1) ? 2'b10 : 2'b01;
                e_rd[(c + 2) % 4]  = (pwe[gi] || errm) ? 32'h0 : memf(pa[gi]);
                e_err[(c + 2) % 4] = errm;
            end
            s = c % 4;
            sample();
            n_cmp++; if ({p1_if.ready, p0_if.ready} !== e_rdy) begin n_bad++; $display("FAIL rand_ready c=%0d: got %b want %b", c, {p1_if.ready, p0_if.ready}, e_rdy); end
            n_cmp++; if ({ram_WE, ram_A} !== {e_we[s], e_a[s]}) begin n_bad++; $display("FAIL rand_ram c=%0d: got we=%b a=%h want we=%b a=%h", c, ram_WE, ram_A, e_we[s], e_a[s]); end
            n_cmp++; if ({p1_if.rvalid, p0_if.rvalid} !== e_rv[s]) begin n_bad++; $display("FAIL rand_rvalid c=%0d: got %b want %b", c, {p1_if.rvalid, p0_if.rvalid}, e_rv[s]); end
            n_cmp++;
            if ({p0_if.RD, p0_if.err} !== (e_rv[s][0] ? {e_rd[s], e_err[s]} : 33'd0) ||
                {p1_if.RD, p1_if.err} !== (e_rv[s][1] ? {e_rd[s], e_err[s]} : 33'd0)) begin
                n_bad++; $display("FAIL rand_resp c=%0d: got p0=%h/%b p1=%h/%b want rd=%h err=%b to %b", c, p0_if.RD, p0_if.err, p1_if.RD, p1_if.err, e_rd[s], e_err[s], e_rv[s]);
            end
            e_we[s] = 1'b0; e_a[s] = 32'h0; e_rv[s] = 2'b00; e_rd[s] = 32'h0; e_err[s] = 1'b0;
            step();
        end
        if (acc_port >= 0) pend[acc_port] = 1'b0;
        n_cmp++; if (pend[0] || pend[1]) begin n_bad++; $display("FAIL rand_drain: got pending %b%b want 00", pend[1], pend[0]); end
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; ovr_en = 1'b0; ovr_val = 32'h0;
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        test_reset();
        test_single_load();
        test_store();
        test_contention();
        test_misaligned();
        test_reset_mid();
        test_payload_stability();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
